rgb_sinp: RTL and testbench

WS2812b serial-input decoder and word packer. Samples the asynchronous WS2812b line, classifies each bit by its high time, assembles 24-bit G-R-B pixels, and writes 32-bit status/colour words into the FIFO that feeds the RGBW serial-output stage. Runs on the 96 MHz PLL clock shared with the FIFO write side.

---
 rtl/rgb_pkg.sv | 40 ++++
 rtl/rgb_sig_sync.sv | 33 +++
 rtl/rgb_sinp.sv | 178 +++++++++++++++++
 tb/tb_rgb_sinp.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB serial-input and serial-output stages:
// FIFO word layout, stream-reset word, default WS2812b timing at 96 MHz.
package rgb_pkg;

   // FIFO word bit numbers
   localparam int BNUM_VALID        = 31;
   localparam int BNUM_STREAM_RESET = 30;
   localparam int G_MSB             = 23;
   localparam int G_LSB             = 16;
   localparam int R_MSB             = 15;
   localparam int R_LSB             = 8;
   localparam int B_MSB             = 7;
   localparam int B_LSB             = 0;

   localparam logic [31:0] WORD_STREAM_RESET = 32'hC000_0000;

   // Default line timing, in 96 MHz clocks
   localparam int DEF_MIN_HIGH    = 10;
   localparam int DEF_BIT_THRESH  = 58;
   localparam int DEF_MAX_HIGH    = 144;
   localparam int DEF_RST_LOW     = 4800;
   localparam int DEF_COUNTER_MAX = 7800;

   // Decoder states (also driven out for debug)
   typedef enum logic [1:0] {
      S_LOW   = 2'd0,
      S_HIGH  = 2'd1,
      S_STUCK = 2'd2
   } sinp_state_t;

   // Pack a G-R-B pixel into a valid FIFO word
   function automatic logic [31:0] pixel_word(input logic [23:0] grb);
      logic [31:0] w;
      w = '0;
      w[BNUM_VALID]  = 1'b1;
      w[G_MSB:B_LSB] = grb;
      return w;
   endfunction

endpackage

// File: rtl/rgb_sig_sync.sv
// Two-flop synchronizer for an asynchronous line input, plus a third flop
// holding the previous synchronized level for edge detection.
module rgb_sig_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_sig,
   output logic sig_lvl,
   output logic rise,
   output logic fall
);

   logic s1_q;
   logic s2_q;
   logic s3_q;

   // Synchronizer chain; s3 remembers the previous s2 level
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= async_sig;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign sig_lvl = s2_q;
   assign rise    = s2_q & ~s3_q;
   assign fall    = ~s2_q & s3_q;

endmodule

// File: rtl/rgb_sinp.sv
// WS2812b serial-input decoder: classifies each high pulse by width,
// assembles 24-bit G-R-B pixels MSB first, and writes pixel and
// stream-reset words into the output FIFO. Drops words when the FIFO is full.
module rgb_sinp
   import rgb_pkg::*;
#(
   parameter int MIN_HIGH    = DEF_MIN_HIGH,
   parameter int BIT_THRESH  = DEF_BIT_THRESH,
   parameter int MAX_HIGH    = DEF_MAX_HIGH,
   parameter int RST_LOW     = DEF_RST_LOW,
   parameter int COUNTER_MAX = DEF_COUNTER_MAX
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_sig,
   input  logic        in_wr_fifo_full,
   output logic        out_wr_fifo_en,
   output logic [31:0] out_wr_fifo_data,
   output logic        out_overflow,
   output logic        out_bit_err,
   output logic [1:0]  out_dbg_state
);

   localparam int CW = $clog2(COUNTER_MAX + 1);

   localparam logic [CW-1:0] MIN_C    = CW'(MIN_HIGH);
   localparam logic [CW-1:0] THRESH_C = CW'(BIT_THRESH);
   localparam logic [CW-1:0] STUCK_AT = CW'(MAX_HIGH - 1);
   localparam logic [CW-1:0] RST_AT   = CW'(RST_LOW - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(COUNTER_MAX);

   // Handshake: out_wr_fifo_en is a one-clock write strobe with no ready
   // return; a word is issued only if in_wr_fifo_full is low in the issuing
   // cycle, otherwise it is dropped and out_overflow latches.

   logic sig_lvl;
   logic sig_rise;
   logic sig_fall;

   rgb_sig_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .async_sig (in_sig),
      .sig_lvl   (sig_lvl),
      .rise      (sig_rise),
      .fall      (sig_fall)
   );

   sinp_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    bit_cnt_q, bit_cnt_d;
   logic          got_bit_q, got_bit_d;
   logic [23:0]   shift_q, shift_d;
   logic          wr_en_q, wr_en_d;
   logic [31:0]   wr_data_q, wr_data_d;
   logic          ovf_q, ovf_d;
   logic          err_q, err_d;

   logic          wr_req;
   logic [31:0]   wr_word;
   logic [23:0]   shifted;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_LOW;
      else     state_q <= state_d;
   end

   // Next-state: edges move between low/high, long high parks in S_STUCK
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LOW:   if (sig_rise) state_d = S_HIGH;
         S_HIGH: begin
            if (sig_fall)               state_d = S_LOW;
            else if (cnt_q == STUCK_AT) state_d = S_STUCK;
         end
         S_STUCK: if (sig_fall) state_d = S_LOW;
         default: state_d = S_LOW;
      endcase
   end

   // Datapath next values: pulse timing, bit assembly and write requests
   always_comb begin
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      got_bit_d = got_bit_q;
      shift_d   = shift_q;
      err_d     = err_q;
      wr_req    = 1'b0;
      wr_word   = wr_data_q;
      shifted   = {shift_q[22:0], (cnt_q >= THRESH_C)};
      case (state_q)
         S_LOW: begin
            if (sig_rise) begin
               cnt_d = CW'(1);
            end else if (!sig_lvl) begin
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
               // cnt passes RST_AT only once per low period
               if (cnt_q == RST_AT) begin
                  if (bit_cnt_q != 5'd0) begin
                     err_d     = 1'b1;
                     bit_cnt_d = 5'd0;
                  end
                  if (got_bit_q) begin
                     wr_req    = 1'b1;
                     wr_word   = WORD_STREAM_RESET;
                     got_bit_d = 1'b0;
                  end
               end
            end
         end
         S_HIGH: begin
            if (sig_fall) begin
               cnt_d = '0;
               // Pulses shorter than MIN_HIGH are glitches and leave no trace
               if (cnt_q >= MIN_C) begin
                  shift_d   = shifted;
                  got_bit_d = 1'b1;
                  if (bit_cnt_q == 5'd23) begin
                     bit_cnt_d = 5'd0;
                     wr_req    = 1'b1;
                     wr_word   = pixel_word(shifted);
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                  end
               end
            end else if (cnt_q == STUCK_AT) begin
               err_d     = 1'b1;
               bit_cnt_d = 5'd0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STUCK: begin
            if (sig_fall) cnt_d = '0;
         end
         default: cnt_d = '0;
      endcase
   end

   // FIFO write issue and overflow tracking
   always_comb begin
      wr_en_d   = wr_req & ~in_wr_fifo_full;
      wr_data_d = wr_en_d ? wr_word : wr_data_q;
      ovf_d     = ovf_q | (wr_req & in_wr_fifo_full);
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         bit_cnt_q <= 5'd0;
         got_bit_q <= 1'b0;
         shift_q   <= 24'd0;
         wr_en_q   <= 1'b0;
         wr_data_q <= 32'd0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         got_bit_q <= got_bit_d;
         shift_q   <= shift_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         ovf_q     <= ovf_d;
         err_q     <= err_d;
      end
   end

   assign out_wr_fifo_en   = wr_en_q;
   assign out_wr_fifo_data = wr_data_q;
   assign out_overflow     = ovf_q;
   assign out_bit_err      = err_q;
   assign out_dbg_state    = state_q;

endmodule

// File: tb/tb_rgb_sinp.sv
// Bench for rgb_sinp: drives WS2812b waveforms and compares FIFO writes and
// sticky flags against a bit-level model of the protocol.
module tb_rgb_sinp;

   localparam int RST_LOW = 4800;

   logic        clk;
   logic        rst;
   logic        in_sig;
   logic        in_wr_fifo_full;
   logic        out_wr_fifo_en;
   logic [31:0] out_wr_fifo_data;
   logic        out_overflow;
   logic        out_bit_err;
   logic [1:0]  out_dbg_state;

   rgb_sinp dut (
      .clk              (clk),
      .rst              (rst),
      .in_sig           (in_sig),
      .in_wr_fifo_full  (in_wr_fifo_full),
      .out_wr_fifo_en   (out_wr_fifo_en),
      .out_wr_fifo_data (out_wr_fifo_data),
      .out_overflow     (out_overflow),
      .out_bit_err      (out_bit_err),
      .out_dbg_state    (out_dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] exp_q[$];
   int          m_nbits = 0;
   logic [23:0] m_pix   = 24'd0;
   bit          m_got   = 0;
   logic        m_err   = 1'b0;
   logic        m_ovf   = 1'b0;
   int          last_fall_cyc = 0;

   task automatic model_push(input logic [31:0] w);
      if (in_wr_fifo_full) m_ovf = 1'b1;
      else                 exp_q.push_back(w);
   endtask

   task automatic model_bit(input bit b);
      m_pix = {m_pix[22:0], b};
      m_got = 1;
      m_nbits++;
      if (m_nbits == 24) begin
         m_nbits = 0;
         model_push({8'h80, m_pix});
      end
   endtask

   task automatic model_stream_reset();
      if (m_nbits != 0) begin
         m_err   = 1'b1;
         m_nbits = 0;
      end
      if (m_got) begin
         model_push(32'hC000_0000);
         m_got = 0;
      end
   endtask

   task automatic model_hw_reset();
      m_nbits = 0;
      m_got   = 0;
      m_err   = 1'b0;
      m_ovf   = 1'b0;
      exp_q.delete();
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst && out_wr_fifo_en) begin
         if (exp_q.size() == 0) begin
            check_eq("wr_unexpected", exp_q.size(), 1);
         end else begin
            logic [31:0] w;
            int lat;
            w   = exp_q.pop_front();
            lat = cyc - last_fall_cyc;
            check_eq("wr_data", out_wr_fifo_data, w);
            if (w[30]) check_eq("rst_word_lat", 32'(lat >= RST_LOW && lat <= RST_LOW + 4), 1);
            else       check_eq("pix_lat", lat, 3);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse(input int hi, input int lo, input bit is_bit, input bit b);
      @(negedge clk);
      in_sig = 1'b1;
      repeat (hi) @(negedge clk);
      if (is_bit) model_bit(b);
      in_sig = 1'b0;
      last_fall_cyc = cyc;
      repeat (lo - 1) @(negedge clk);
   endtask

   task automatic send_bit(input bit b, input bit fixed);
      if (fixed) begin
         if (b) pulse(77, 43, 1, 1'b1);
         else   pulse(38, 82, 1, 1'b0);
      end else begin
         pulse(b ? $urandom_range(100, 62) : $urandom_range(50, 14),
               $urandom_range(60, 20), 1, b);
      end
   endtask

   task automatic glitch();
      pulse(5, $urandom_range(40, 20), 0, 1'b0);
   endtask

   task automatic stuck_high();
      pulse(200, 40, 0, 1'b0);
      m_err   = 1'b1;
      m_nbits = 0;
   endtask

   task automatic send_bits(input logic [23:0] pix, input int nbits, input bit fixed, input bit glitches);
      for (int i = 23; i > 23 - nbits; i--) begin
         send_bit(pix[i], fixed);
         if (glitches && i > 24 - nbits) glitch();
      end
   endtask

   task automatic send_low(input int n);
      model_stream_reset();
      in_sig = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_flags(input string tag);
      check_eq({tag, "_ovf"}, out_overflow, m_ovf);
      check_eq({tag, "_err"}, out_bit_err, m_err);
      check_eq({tag, "_drained"}, exp_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      in_sig = 1'b0;
      in_wr_fifo_full = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("rst_en", out_wr_fifo_en, 0);
      check_eq("rst_data", out_wr_fifo_data, 0);
      check_eq("rst_ovf", out_overflow, 0);
      check_eq("rst_err", out_bit_err, 0);
      check_eq("rst_state", out_dbg_state, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Nominal pixel followed by stream reset
      check_eq("model_pix1", {8'h80, 24'hA53C0F}, 32'h80A5_3C0F);
      send_bits(24'hA53C0F, 24, 1, 0);
      send_low(5000);
      check_flags("t1");

      // Partial pixel at stream reset
      send_bits(24'h123456, 12, 0, 0);
      send_low(5000);
      check_flags("t2");

      // FIFO full: pixel and reset word dropped, got_bit still cleared
      in_wr_fifo_full = 1'b1;
      send_bits(24'($urandom), 24, 0, 0);
      send_low(5000);
      in_wr_fifo_full = 1'b0;
      send_low(5000);
      check_flags("t3");

      // Glitches between bits, then stuck-high mid-pixel, then recovery
      send_bits(24'h00FF00, 24, 0, 1);
      send_bits(24'h5A5A5A, 8, 0, 0);
      stuck_high();
      check_eq("stuck_err", out_bit_err, 1);
      send_bits(24'hC3A10E, 24, 0, 0);
      send_low(5000);
      check_flags("t4");

      // Mid-frame synchronous reset
      send_bits(24'hFFFFFF, 20, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      model_hw_reset();
      @(negedge clk);
      check_eq("mid_rst_en", out_wr_fifo_en, 0);
      check_eq("mid_rst_data", out_wr_fifo_data, 0);
      check_eq("mid_rst_ovf", out_overflow, 0);
      check_eq("mid_rst_err", out_bit_err, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      send_bits(24'h0A0B0C, 24, 0, 0);
      send_low(5000);
      check_flags("t5");

      // Randomized pixels with random FIFO-full and glitches
      for (int p = 0; p < 8; p++) begin
         in_wr_fifo_full = ($urandom_range(3, 0) == 0);
         send_bits(24'($urandom), 24, 0, $urandom_range(1, 0) == 1);
         if (p == 3 || p == 7) send_low(5000);
      end
      in_wr_fifo_full = 1'b0;
      repeat (10) @(negedge clk);
      check_flags("rand");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
